// File: rtl/tx_rx_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tx_rx_pkg
//  Description : Shared defaults, level-width helper and producer register
//                type for the tx_rx_buf link block.
//  Revision    : 1.0 - initial release
// ============================================================================
package tx_rx_pkg;

    localparam int N_DEF     = 4;
    localparam int DEPTH_DEF = 4;
    localparam int DW_DEF    = 8;

    // Occupancy needs to represent 0..DEPTH inclusive.
    function automatic int lvl_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Producer holding register at the default word width.
    typedef struct packed {
        logic              valid;
        logic [N_DEF-1:0]  data;
    } prod_reg_t;

endpackage
`default_nettype wire

// File: rtl/tx_rx_buf_if.sv
`default_nettype none
// ============================================================================
//  Module      : tx_rx_buf_if
//  Description : Source/sink-facing signal bundle of tx_rx_buf. The slave
//                modport is the buffer itself, master is its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tx_rx_buf_if
    import tx_rx_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int DW    = DW_DEF
);
    logic                          tx;
    logic                          busy;
    logic [N-1:0]                  rx_data;
    logic                          rx_valid;
    logic [lvl_width(DEPTH)-1:0]   level;
    logic                          full;
    logic                          empty;
    logic [DW-1:0]                 drop_cnt;

    modport slave (
        input  tx, busy,
        output rx_data, rx_valid, level, full, empty, drop_cnt
    );

    modport master (
        output tx, busy,
        input  rx_data, rx_valid, level, full, empty, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/tx_rx_buf_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : DEPTH-entry synchronous FIFO with wrap-bit pointers.
//                Read data is the current head word (combinational).
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import tx_rx_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    input  wire logic                          push,
    input  wire logic [N-1:0]                  wdata,
    input  wire logic                          pop,
    output logic      [N-1:0]                  rdata,
    output logic                               full,
    output logic                               empty,
    output logic      [lvl_width(DEPTH)-1:0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = lvl_width(DEPTH);

    logic [N-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_do_push;
    logic         w_do_pop;
    logic [AW:0]  w_diff;

    // A push into a full FIFO is refused even when a pop happens alongside.
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    assign empty  = (r_wptr == r_rptr);
    assign full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_diff = r_wptr - r_rptr;
    assign level  = LW'(w_diff);
    assign rdata  = r_mem[r_rptr[AW-1:0]];

    // Pointer advance; both move when push and pop coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= wdata;
    end
endmodule
`default_nettype wire

// File: rtl/tx_rx_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tx_rx_buf
//  Description : Strobe-driven word producer feeding a FIFO that a
//                busy-throttled consumer drains; counts dropped strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_rx_buf
    import tx_rx_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int DW    = DW_DEF
) (
    input  wire logic        clk,
    input  wire logic        rst,
    tx_rx_buf_if.slave       bus
);
    typedef struct packed {
        logic          valid;
        logic [N-1:0]  data;
    } prod_t;

    prod_t                         r_prod;
    logic [N-1:0]                  r_gen;
    logic [DW-1:0]                 r_drop;
    logic [N-1:0]                  r_rx_data;
    logic                          r_rx_valid;

    logic                          w_full;
    logic                          w_empty;
    logic [lvl_width(DEPTH)-1:0]   w_level;
    logic [N-1:0]                  w_rdata;
    logic                          w_accept;
    logic                          w_pop;

    // Ready is the registered full flag; no same-cycle bypass on a pop.
    assign w_accept = r_prod.valid & ~w_full;
    assign w_pop    = ~w_empty & ~bus.busy;

    sync_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_accept),
        .wdata (r_prod.data),
        .pop   (w_pop),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    // Producer: load a new sequence word when the slot is free or emptying.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod <= '0;
            r_gen  <= '0;
        end else if (bus.tx && (!r_prod.valid || w_accept)) begin
            r_prod <= '{valid: 1'b1, data: r_gen};
            r_gen  <= r_gen + N'(1);
        end else if (w_accept) begin
            r_prod.valid <= 1'b0;
        end
    end

    // Saturating count of strobes lost while the held word is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop <= '0;
        end else if (bus.tx && r_prod.valid && !w_accept && (r_drop != '1)) begin
            r_drop <= r_drop + DW'(1);
        end
    end

    // Consumer register: capture the head word on each pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= w_pop;
            if (w_pop) r_rx_data <= w_rdata;
        end
    end

    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.level    = w_level;
    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.drop_cnt = r_drop;
endmodule
`default_nettype wire

// File: tb/tb_tx_rx_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_rx_buf
//  Description : Self-checking bench for tx_rx_buf: directed vector table,
//                hand-written corner sequences and random traffic against a
//                queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_rx_buf;
    localparam int N      = 4;
    localparam int DEPTH  = 4;
    localparam int DW     = 8;
    localparam int DW_SAT = 2;
    localparam int SEQ_MOD  = 1 << N;
    localparam int DROP_MAX = (1 << DW) - 1;
    localparam int SAT_MAX  = (1 << DW_SAT) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tx_rx_buf_if #(.N(N), .DEPTH(DEPTH), .DW(DW))     bus();
    tx_rx_buf_if #(.N(N), .DEPTH(DEPTH), .DW(DW_SAT)) bus_sat();

    assign bus_sat.tx   = bus.tx;
    assign bus_sat.busy = bus.busy;

    tx_rx_buf #(.N(N), .DEPTH(DEPTH), .DW(DW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    tx_rx_buf #(.N(N), .DEPTH(DEPTH), .DW(DW_SAT)) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_sat)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int q[$];
    int m_gen, m_pd, m_drop, m_rd;
    bit m_pv, m_rv;
    int exp_seq, rcv;

    typedef struct {
        logic tx;
        logic busy;
        int   rv;
        int   rd;
        int   lvl;
        int   drop;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_gen = 0; m_pd = 0; m_pv = 0; m_drop = 0;
        m_rv = 0;  m_rd = 0; exp_seq = 0; rcv = 0;
    endtask

    task automatic model_step(input bit t, input bit b);
        bit f, acc, pop;
        f   = (q.size() == DEPTH);
        acc = m_pv && !f;
        pop = (q.size() != 0) && !b;
        if (pop) begin
            m_rd = q.pop_front();
            m_rv = 1;
        end else begin
            m_rv = 0;
        end
        if (acc) q.push_back(m_pd);
        if (t && (!m_pv || acc)) begin
            m_pd  = m_gen;
            m_gen = (m_gen + 1) % SEQ_MOD;
            m_pv  = 1;
        end else if (t) begin
            if (m_drop < DROP_MAX) m_drop++;
        end else if (acc) begin
            m_pv = 0;
        end
    endtask

    task automatic compare_all();
        int sat;
        sat = (m_drop > SAT_MAX) ? SAT_MAX : m_drop;
        chk("rx_valid", 32'(bus.rx_valid), 32'(m_rv));
        chk("rx_data",  32'(bus.rx_data),  32'(m_rd));
        chk("level",    32'(bus.level),    32'(q.size()));
        chk("full",     32'(bus.full),     32'(q.size() == DEPTH));
        chk("empty",    32'(bus.empty),    32'(q.size() == 0));
        chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
        chk("drop_cnt_sat", 32'(bus_sat.drop_cnt), 32'(sat));
        if (bus.rx_valid === 1'b1) begin
            chk("order", 32'(bus.rx_data), 32'(exp_seq));
            exp_seq = (exp_seq + 1) % SEQ_MOD;
            rcv++;
        end
    endtask

    task automatic step(input logic t, input logic b);
        @(negedge clk);
        bus.tx   = t;
        bus.busy = b;
        model_step(t, b);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        bus.tx   = 1'b0;
        bus.busy = 1'b0;
        model_reset();
        #1;
        chk("rst_level",    32'(bus.level),    32'd0);
        chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("rst_empty",    32'(bus.empty),    32'd1);
        chk("rst_full",     32'(bus.full),     32'd0);
        chk("rst_drop",     32'(bus.drop_cnt), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.tx   = 1'b0;
        bus.busy = 1'b0;
        model_reset();

        // Single-pulse latency and hold behaviour, expected values by hand
        tbl[0] = '{1'b1, 1'b0, 0, 0, 0, 0};
        tbl[1] = '{1'b0, 1'b0, 0, 0, 1, 0};
        tbl[2] = '{1'b0, 1'b0, 1, 0, 0, 0};
        tbl[3] = '{1'b0, 1'b0, 0, 0, 0, 0};
        tbl[4] = '{1'b1, 1'b0, 0, 0, 0, 0};
        tbl[5] = '{1'b0, 1'b0, 0, 0, 1, 0};
        tbl[6] = '{1'b0, 1'b0, 1, 1, 0, 0};
        tbl[7] = '{1'b0, 1'b0, 0, 1, 0, 0};

        do_reset();

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            chk("idle_rx_valid", 32'(bus.rx_valid), 32'd0);
        end

        // Directed table
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].tx, tbl[i].busy);
            chk("tbl_rx_valid", 32'(bus.rx_valid), 32'(tbl[i].rv));
            chk("tbl_rx_data",  32'(bus.rx_data),  32'(tbl[i].rd));
            chk("tbl_level",    32'(bus.level),    32'(tbl[i].lvl));
            chk("tbl_drop",     32'(bus.drop_cnt), 32'(tbl[i].drop));
        end

        // Sustained burst with wrap
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++)  step(1'b0, 1'b0);
        chk("burst_count", 32'(rcv), 32'd20);
        chk("burst_drop",  32'(bus.drop_cnt), 32'd0);

        // Fill under busy, then single-cycle release while producer holds
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
        chk("fill_level", 32'(bus.level),    32'd4);
        chk("fill_full",  32'(bus.full),     32'd1);
        chk("fill_drop",  32'(bus.drop_cnt), 32'd3);
        step(1'b0, 1'b0);
        chk("toggle_level_pop",  32'(bus.level),   32'd3);
        chk("toggle_rx_data",    32'(bus.rx_data), 32'd0);
        step(1'b0, 1'b1);
        chk("toggle_level_push", 32'(bus.level),   32'd4);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
        chk("drain_count", 32'(rcv), 32'd5);

        // Reset with three words buffered
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        chk("pre_rst_level", 32'(bus.level), 32'd3);
        do_reset();

        // Drop counter saturation on the narrow instance
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1);
        chk("sat_drop_narrow", 32'(bus_sat.drop_cnt), 32'd3);
        chk("sat_drop_wide",   32'(bus.drop_cnt),     32'd7);

        // Random traffic with occasional resets
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int busy_pct;
            if (i % 150 == 149) do_reset();
            busy_pct = ((i / 50) % 3) * 40;
            step(logic'($urandom_range(0, 3) != 0),
                 logic'(int'($urandom_range(0, 99)) < busy_pct));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
